// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-addressed data memory: access sizes and dump FSM states.
package dmem_pkg;

    typedef logic [1:0] size_t;

    localparam size_t SZ_BYTE  = 2'b00;
    localparam size_t SZ_HALF  = 2'b01;
    localparam size_t SZ_WORD  = 2'b10;
    localparam size_t SZ_DWORD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DUMP = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Number of bytes touched by an access of the given size.
    function automatic int unsigned size_bytes(input size_t sz);
        return 32'd1 << sz;
    endfunction

endpackage

// File: rtl/dmem_byte_ram_if.sv
// Access and dump bus of dmem_byte_ram; master drives requests, slave is the memory.
interface dmem_byte_ram_if
    import dmem_pkg::*;
#(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 8
);
    logic               i_en;
    logic               i_we;
    size_t              i_size;
    logic               i_unsigned;
    logic [NB_ADDR-1:0] i_addr;
    logic [NB_DATA-1:0] i_data;
    logic [NB_DATA-1:0] o_data;
    logic               o_valid;
    logic               o_err;
    logic               i_dump_start;
    logic               i_dump_ready;
    logic [NB_DATA-1:0] o_dump_data;
    logic               o_dump_valid;
    logic               o_dump_done;
    logic               o_busy;

    modport master (
        output i_en, i_we, i_size, i_unsigned, i_addr, i_data, i_dump_start, i_dump_ready,
        input  o_data, o_valid, o_err, o_dump_data, o_dump_valid, o_dump_done, o_busy
    );

    modport slave (
        input  i_en, i_we, i_size, i_unsigned, i_addr, i_data, i_dump_start, i_dump_ready,
        output o_data, o_valid, o_err, o_dump_data, o_dump_valid, o_dump_done, o_busy
    );
endinterface

// File: rtl/dmem_load_align.sv
// Load alignment: takes the big-endian window starting at the access address and
// right-justifies the accessed unit, sign- or zero-extending it to NB_DATA.
module dmem_load_align
    import dmem_pkg::*;
#(
    parameter int unsigned NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] win,
    input  size_t              size,
    input  logic               is_unsigned,
    output logic [NB_DATA-1:0] data_c
);
    logic [63:0] win64;
    logic [63:0] ext;

    // Work in a 64-bit frame with the addressed byte at the top, then truncate.
    always_comb begin
        win64  = 64'(win) << (64 - NB_DATA);
        ext    = '0;
        case (size)
            SZ_BYTE: ext = {{56{win64[63] & ~is_unsigned}}, win64[63:56]};
            SZ_HALF: ext = {{48{win64[63] & ~is_unsigned}}, win64[63:48]};
            SZ_WORD: ext = {{32{win64[63] & ~is_unsigned}}, win64[63:32]};
            default: ext = win64;
        endcase
        data_c = NB_DATA'(ext);
    end

endmodule

// File: rtl/dmem_byte_ram.sv
// Big-endian byte-addressed data RAM with 1-cycle registered load response.
// Optional whole-memory dump streamer enabled by defining DMEM_DUMP_EN.
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 8
) (
    input  logic          clk,
    input  logic          i_rst,
    dmem_byte_ram_if.slave bus
);
    localparam int unsigned NBYTES = NB_DATA / 8;
    localparam int unsigned DEPTH  = 1 << NB_ADDR;

    logic [7:0]         mem [DEPTH];
    logic               busy_c;
    logic               acc_c;
    logic               legal_c;
    logic               wr_c;
    int unsigned        nb_c;
    logic [NB_ADDR-1:0] rd_addr_c;
    logic [NB_DATA-1:0] rd_win_c;
    logic [NB_DATA-1:0] load_c;
    logic [NB_DATA-1:0] data_q;
    logic               valid_q;
    logic               err_q;

    assign nb_c    = size_bytes(bus.i_size);
    assign legal_c = ((bus.i_addr & NB_ADDR'(nb_c - 1)) == '0) &&
                     ((bus.i_size != SZ_DWORD) || (NB_DATA == 64));
    assign acc_c   = bus.i_en & ~busy_c;
    assign wr_c    = acc_c & bus.i_we & legal_c;

    // Byte at the access address is the most significant byte of the store unit.
    always_ff @(posedge clk) begin
        if (wr_c) begin
            for (int unsigned k = 0; k < NBYTES; k++) begin
                if (k < nb_c) begin
                    mem[bus.i_addr + NB_ADDR'(k)] <= bus.i_data[8*(nb_c-1-k) +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_win_c = '0;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            rd_win_c[NB_DATA-1-8*k -: 8] = mem[rd_addr_c + NB_ADDR'(k)];
        end
    end

    dmem_load_align #(.NB_DATA(NB_DATA)) u_align (
        .win         (rd_win_c),
        .size        (bus.i_size),
        .is_unsigned (bus.i_unsigned),
        .data_c      (load_c)
    );

    // Response register: stores and illegal accesses answer with zero data.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= acc_c;
            err_q   <= acc_c & ~legal_c;
            if (acc_c) begin
                data_q <= (legal_c && !bus.i_we) ? load_c : '0;
            end
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
    assign bus.o_err   = err_q;

`ifdef DMEM_DUMP_EN
    localparam logic [NB_ADDR-1:0] PTR_LAST = ~NB_ADDR'(NBYTES - 1);

    logic [1:0]         state_q,      state_d;
    logic [NB_ADDR-1:0] ptr_q,        ptr_d;
    logic [NB_DATA-1:0] dump_data_q,  dump_data_d;
    logic               dump_valid_q, dump_valid_d;
    logic               dump_done_q,  dump_done_d;
    logic               busy_q,       busy_d;

    assign busy_c = (state_q != ST_IDLE);

    // Share the read port: prefetch the next dump word while streaming.
    always_comb begin
        if (state_q == ST_DUMP) begin
            rd_addr_c = ptr_q + NB_ADDR'(NBYTES);
        end else if (bus.i_en) begin
            rd_addr_c = bus.i_addr;
        end else begin
            rd_addr_c = '0;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
            dump_done_q  <= dump_done_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        dump_data_d  = dump_data_q;
        dump_valid_d = dump_valid_q;
        dump_done_d  = 1'b0;
        busy_d       = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_dump_start && !bus.i_en) begin
                    state_d      = ST_DUMP;
                    ptr_d        = '0;
                    dump_data_d  = rd_win_c;
                    dump_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            ST_DUMP: begin
                if (bus.i_dump_ready) begin
                    if (ptr_q == PTR_LAST) begin
                        state_d      = ST_DONE;
                        dump_valid_d = 1'b0;
                        dump_done_d  = 1'b1;
                    end else begin
                        ptr_d       = ptr_q + NB_ADDR'(NBYTES);
                        dump_data_d = rd_win_c;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                ptr_d        = '0;
                dump_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    assign bus.o_dump_data  = dump_data_q;
    assign bus.o_dump_valid = dump_valid_q;
    assign bus.o_dump_done  = dump_done_q;
    assign bus.o_busy       = busy_q;
`else
    logic unused_dump;

    assign busy_c           = 1'b0;
    assign rd_addr_c        = bus.i_addr;
    assign unused_dump      = bus.i_dump_start ^ bus.i_dump_ready;
    assign bus.o_dump_data  = '0;
    assign bus.o_dump_valid = 1'b0;
    assign bus.o_dump_done  = 1'b0;
    assign bus.o_busy       = 1'b0;
`endif

endmodule
